gcd_controller: RTL and testbench

Control FSM at the other end of the GCD datapath's control/status interface. It drives ldA, ldB, sel1, sel2 and sel_load, and consumes the lt, gt and eq comparator flags. It accepts two 16-bit operands over a valid/ready handshake and runs subtraction-based GCD, one subtraction per clock. It reports the result (the datapath's Aout) or an error via a held done/err level that is cleared by ack. The top level wires in_data to both this block and the datapath's data_in.

---
 rtl/gcd_controller.sv | 156 +++++++++++++++
 tb/tb_gcd_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_controller.sv
// ----------------------------------------------------------------------------
// gcd_controller
//   Control FSM for a subtraction-based GCD datapath. Accepts operand A then
//   operand B over a valid/ready handshake, steers the datapath one
//   subtraction per clock until the comparator reports equality, then holds
//   done (or err) until the consumer acknowledges.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake
//   in_data             operand value, only examined for zero detection
//   ack                 consumer acknowledge for done/err
//   lt, gt, eq          datapath comparator flags (A<B, A>B, A==B)
//   ldA, ldB            datapath register load enables
//   sel1, sel2          subtractor minuend/subtrahend select (0=A, 1=B)
//   sel_load            register bus select (1=in_data, 0=subtractor)
//   done, err           held result / abort levels
//   err_code            01=zero operand, 10=timeout, 00=none
//   iter_count          subtractions performed in the current/last run
// ----------------------------------------------------------------------------
module gcd_controller #(
    parameter int ITER_W   = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_data,
    input  logic              ack,
    input  logic              lt,
    input  logic              gt,
    input  logic              eq,
    output logic              ldA,
    output logic              ldB,
    output logic              sel1,
    output logic              sel2,
    output logic              sel_load,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ITER_W-1:0] iter_count
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_B,
        RUN,
        DONE,
        ERR
    } state_t;

    localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ZERO    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    state_t            state, state_n;
    logic              a_zero, a_zero_n;
    logic [ITER_W-1:0] iter_n;
    logic [1:0]        err_code_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_zero     <= 1'b0;
            iter_count <= '0;
            err_code   <= ERR_NONE;
        end else begin
            state      <= state_n;
            a_zero     <= a_zero_n;
            iter_count <= iter_n;
            err_code   <= err_code_n;
        end
    end

    always_comb begin
        state_n    = state;
        a_zero_n   = a_zero;
        iter_n     = iter_count;
        err_code_n = err_code;
        in_ready   = 1'b0;
        sel_load   = 1'b0;
        ldA        = 1'b0;
        ldB        = 1'b0;
        sel1       = 1'b0;
        sel2       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                sel_load = 1'b1;
                if (in_valid) begin
                    ldA      = 1'b1;
                    a_zero_n = (in_data == 16'd0);
                    state_n  = WAIT_B;
                end
            end

            WAIT_B: begin
                in_ready = 1'b1;
                sel_load = 1'b1;
                if (in_valid) begin
                    ldB    = 1'b1;
                    iter_n = '0;
                    if (a_zero || (in_data == 16'd0)) begin
                        err_code_n = ERR_ZERO;
                        state_n    = ERR;
                    end else begin
                        err_code_n = ERR_NONE;
                        state_n    = RUN;
                    end
                end
            end

            RUN: begin
                // eq wins over timeout so a run finishing exactly on the
                // last allowed subtraction still reports a result.
                if (eq) begin
                    state_n = DONE;
                end else if (iter_count == MAX_ITER_C) begin
                    err_code_n = ERR_TIMEOUT;
                    state_n    = ERR;
                end else if (gt) begin
                    sel2   = 1'b1;
                    ldA    = 1'b1;
                    iter_n = iter_count + ITER_W'(1);
                end else if (lt) begin
                    sel1   = 1'b1;
                    ldB    = 1'b1;
                    iter_n = iter_count + ITER_W'(1);
                end else begin
                    // No comparator flag is an inconsistent datapath; abort
                    // the same way as a timeout.
                    err_code_n = ERR_TIMEOUT;
                    state_n    = ERR;
                end
            end

            DONE: begin
                done = 1'b1;
                if (ack) state_n = IDLE;
            end

            ERR: begin
                err = 1'b1;
                if (ack) state_n = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gcd_controller.sv
module tb_gcd_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        ack;

    // Main instance (default MAX_ITER) and its datapath model.
    logic        in_ready, ldA, ldB, sel1, sel2, sel_load, done, err, lt, gt, eq;
    logic [1:0]  err_code;
    logic [15:0] iter_count;
    logic [15:0] ra, rb, bus;

    // Short-timeout instance sharing the same stimulus.
    logic        t_in_ready, t_ldA, t_ldB, t_sel1, t_sel2, t_sel_load, t_done, t_err;
    logic        t_lt, t_gt, t_eq;
    logic [1:0]  t_err_code;
    logic [15:0] t_iter_count;
    logic [15:0] ta, tb, t_bus;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gcd_controller dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .ack(ack), .lt(lt), .gt(gt), .eq(eq),
        .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2), .sel_load(sel_load),
        .done(done), .err(err), .err_code(err_code), .iter_count(iter_count)
    );

    gcd_controller #(.ITER_W(16), .MAX_ITER(3)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
        .in_data(in_data), .ack(ack), .lt(t_lt), .gt(t_gt), .eq(t_eq),
        .ldA(t_ldA), .ldB(t_ldB), .sel1(t_sel1), .sel2(t_sel2), .sel_load(t_sel_load),
        .done(t_done), .err(t_err), .err_code(t_err_code), .iter_count(t_iter_count)
    );

    // Datapath models: mux, subtractor, A/B registers, comparator.
    assign bus   = sel_load ? in_data : ((sel1 ? rb : ra) - (sel2 ? rb : ra));
    assign lt    = ra < rb;
    assign gt    = ra > rb;
    assign eq    = ra == rb;
    always @(posedge clk) begin
        if (ldA) ra <= bus;
        if (ldB) rb <= bus;
    end

    assign t_bus = t_sel_load ? in_data : ((t_sel1 ? tb : ta) - (t_sel2 ? tb : ta));
    assign t_lt  = ta < tb;
    assign t_gt  = ta > tb;
    assign t_eq  = ta == tb;
    always @(posedge clk) begin
        if (t_ldA) ta <= t_bus;
        if (t_ldB) tb <= t_bus;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A handshake edge, then B handshake edge; in_valid dropped afterwards.
    task automatic load_ab(input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        in_data  = a;
        tick();
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 16'd0;
    endtask

    // Edges until main instance shows done or err, bounded.
    task automatic wait_main(output int n);
        n = 0;
        while (!(done || err) && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        int         n;
        int         pulses;
        logic [9:0] pat;
        logic       any_load;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 16'd0;
        ack      = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sel_load", sel_load, 1);
        chk("rst_loads", {ldA, ldB, sel1, sel2}, 0);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_iter", iter_count, 0);
        chk("rst_err_code", err_code, 0);
        rst = 1'b0;
        tick();

        // 48,18 -> A=30, A=12, B=6, A=6, eq
        load_ab(16'd48, 16'd18);
        chk("s1_not_ready_in_run", in_ready, 0);
        pat = '0;
        n   = 0;
        while (!done && n < 50) begin
            pat = {pat[7:0], ldA, ldB};
            tick();
            n++;
        end
        chk("s1_latency", n, 5);
        chk("s1_load_pattern", pat, 10'b10_10_01_10_00);
        chk("s1_aout", ra, 6);
        chk("s1_iter", iter_count, 4);
        chk("s1_err_code", err_code, 0);
        tick();
        tick();
        chk("s1_done_held", {done, in_ready, ldA, ldB}, 4'b1000);
        pulse_ack();
        chk("s1_ack_idle", {done, in_ready}, 2'b01);
        chk("s1_iter_frozen", iter_count, 4);

        // 7,7 -> no loads, done after one edge
        load_ab(16'd7, 16'd7);
        chk("s2_run_no_load", {ldA, ldB}, 0);
        wait_main(n);
        chk("s2_latency", n, 1);
        chk("s2_iter", iter_count, 0);
        chk("s2_aout", ra, 7);
        pulse_ack();

        // 0,5 -> zero-operand error straight from WAIT_B
        load_ab(16'd0, 16'd5);
        chk("s3_err", {err, done}, 2'b10);
        chk("s3_err_code", err_code, 1);
        chk("s3_no_load", {ldA, ldB}, 0);
        tick();
        tick();
        tick();
        chk("s3_err_held", {err, err_code}, 3'b101);
        pulse_ack();
        chk("s3_ack_idle", {err, in_ready}, 2'b01);
        pulse_ack();
        chk("s3_ack_in_idle_ignored", {in_ready, err, done}, 3'b100);

        // 100,1 on the MAX_ITER=3 instance -> three ldA pulses, then timeout
        load_ab(16'd100, 16'd1);
        pulses = 0;
        n      = 0;
        while (!t_err && n < 50) begin
            if (t_ldA) pulses++;
            tick();
            n++;
        end
        chk("s4_t_latency", n, 4);
        chk("s4_t_pulses", pulses, 3);
        chk("s4_t_a", ta, 97);
        chk("s4_t_err_code", t_err_code, 2);
        chk("s4_t_iter", t_iter_count, 3);
        wait_main(n);
        chk("s4_main_done", {done, err}, 2'b10);
        chk("s4_main_iter", iter_count, 99);
        chk("s4_main_aout", ra, 1);
        pulse_ack();

        // 65535,1 aborted by asynchronous reset mid-run
        load_ab(16'hFFFF, 16'd1);
        repeat (10) tick();
        chk("s5_running", {ldA, in_ready}, 2'b10);
        #2 rst = 1'b1;
        #1;
        chk("s5_rst_ready", in_ready, 1);
        chk("s5_rst_outs", {done, err, ldA, ldB}, 0);
        chk("s5_rst_iter", iter_count, 0);
        #1 rst = 1'b0;
        tick();
        load_ab(16'd48, 16'd18);
        chk("s5_err_code_clr", err_code, 0);
        wait_main(n);
        chk("s5_latency", n, 5);
        chk("s5_aout", ra, 6);

        // ack + in_valid in DONE: operand taken only on the following cycle
        in_valid = 1'b1;
        in_data  = 16'd9;
        tick();
        chk("s6_done_ignores_valid", {done, in_ready, ldA}, 3'b100);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("s6_a_not_taken", ra, 6);
        chk("s6_idle_ready", {in_ready, ldA}, 2'b11);
        tick();
        chk("s6_a_taken", ra, 9);
        in_data = 16'd3;
        tick();
        in_valid = 1'b0;
        wait_main(n);
        chk("s6_latency", n, 3);
        chk("s6_aout", ra, 3);
        chk("s6_iter", iter_count, 2);
        pulse_ack();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
